// File: rtl/graph_fanout_enqueuer_pkg.sv
// Shared task/AXI types and FSM encoding for the graph fan-out enqueuer.
package graph_fanout_enqueuer_pkg;

  typedef logic [31:0] ts_t;

  typedef struct packed {
    logic [3:0]  ttype;
    ts_t         ts;
    logic [31:0] hint;
    logic [63:0] args;
  } task_t;

  localparam int unsigned TQ_WIDTH = $bits(task_t);
  localparam logic [2:0]  AXI_SIZE_4B = 3'd2;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RD_BOFS, ST_WT_BOFS, ST_RD_BNBR, ST_WT_BNBR,
    ST_RD_EDGE, ST_WT_EDGE, ST_RD_NBR, ST_WT_NBR, ST_SPLIT, ST_DONE
  } fanout_state_t;

  // Widened to 33 bits so a wrapped s/e pair can never look like a short range.
  function automatic logic [7:0] nbr_burst_len(logic [31:0] s, logic [31:0] e,
                                               int unsigned chunk);
    logic [32:0] span;
    span = {1'b0, e} - {1'b0, s};
    if (span > 33'(chunk)) return 8'(chunk - 1);
    return 8'(span - 33'd1);
  endfunction

endpackage

// File: rtl/graph_fanout_enqueuer_if.sv
// L1 AXI read port, tied-off write channels and child task stream.
interface graph_fanout_enqueuer_if;
  logic                                        m_axi_l1_V_ARVALID;
  logic                                        m_axi_l1_V_ARREADY;
  logic [31:0]                                 m_axi_l1_V_ARADDR;
  logic [7:0]                                  m_axi_l1_V_ARLEN;
  logic [2:0]                                  m_axi_l1_V_ARSIZE;
  logic                                        m_axi_l1_V_RVALID;
  logic                                        m_axi_l1_V_RREADY;
  logic [31:0]                                 m_axi_l1_V_RDATA;
  logic                                        m_axi_l1_V_RLAST;
  logic [1:0]                                  m_axi_l1_V_RRESP;
  logic                                        m_axi_l1_V_AWVALID;
  logic                                        m_axi_l1_V_WVALID;
  logic                                        m_axi_l1_V_BREADY;
  logic [graph_fanout_enqueuer_pkg::TQ_WIDTH-1:0] task_out_V_TDATA;
  logic                                        task_out_V_TVALID;
  logic                                        task_out_V_TREADY;

  modport master (
    output m_axi_l1_V_ARVALID, m_axi_l1_V_ARADDR, m_axi_l1_V_ARLEN, m_axi_l1_V_ARSIZE,
    input  m_axi_l1_V_ARREADY,
    input  m_axi_l1_V_RVALID, m_axi_l1_V_RDATA, m_axi_l1_V_RLAST, m_axi_l1_V_RRESP,
    output m_axi_l1_V_RREADY,
    output m_axi_l1_V_AWVALID, m_axi_l1_V_WVALID, m_axi_l1_V_BREADY,
    output task_out_V_TDATA, task_out_V_TVALID,
    input  task_out_V_TREADY
  );

  modport slave (
    input  m_axi_l1_V_ARVALID, m_axi_l1_V_ARADDR, m_axi_l1_V_ARLEN, m_axi_l1_V_ARSIZE,
    output m_axi_l1_V_ARREADY,
    output m_axi_l1_V_RVALID, m_axi_l1_V_RDATA, m_axi_l1_V_RLAST, m_axi_l1_V_RRESP,
    input  m_axi_l1_V_RREADY,
    input  m_axi_l1_V_AWVALID, m_axi_l1_V_WVALID, m_axi_l1_V_BREADY,
    input  task_out_V_TDATA, task_out_V_TVALID,
    output task_out_V_TREADY
  );
endinterface

// File: rtl/graph_fanout_enqueuer_child_fmt.sv
// Packs one neighbour word into a child task; owns the relative-timestamp adder.
module fanout_child_fmt
  import graph_fanout_enqueuer_pkg::*;
#(
  parameter int unsigned TS_BITS     = 24,
  parameter int unsigned PORT_BITS   = 2,
  parameter int unsigned CHILD_TTYPE = 0,
  parameter bit          REL_TS      = 1'b0
) (
  input  logic [31:0] nbr_i,
  input  ts_t         pts_i,
  input  logic [31:0] vid_i,
  output task_t       child_o
);
  logic [TS_BITS-1:0] weight, ts;
  logic               unused_ok;

  assign weight    = nbr_i[TS_BITS-1:0];
  assign ts        = REL_TS ? (pts_i[TS_BITS-1:0] + weight) : weight;
  assign unused_ok = ^{nbr_i, pts_i};

  always_comb begin
    child_o                       = '0;
    child_o.ttype                 = 4'(CHILD_TTYPE);
    child_o.ts                    = ts_t'(ts);
    child_o.hint                  = vid_i;
    child_o.args[PORT_BITS-1:0]   = nbr_i[TS_BITS +: PORT_BITS];
  end
endmodule

// File: rtl/graph_fanout_enqueuer.sv
// Walks a vertex's CSR edge range in L1 and emits one child task per neighbour,
// plus a continuation task when the range exceeds CHUNK.
module graph_fanout_enqueuer
  import graph_fanout_enqueuer_pkg::*;
#(
  parameter int unsigned CORE_ID       = 0,
  parameter int unsigned TILE_ID       = 0,
  parameter int unsigned CHUNK         = 7,
  parameter logic [31:0] BASE_OFS_ADDR = 32'h20,
  parameter logic [31:0] BASE_NBR_ADDR = 32'h24,
  parameter int unsigned TS_BITS       = 24,
  parameter int unsigned PORT_BITS     = 2,
  parameter int unsigned CHILD_TTYPE   = 0,
  parameter int unsigned SPLIT_TTYPE   = 1,
  parameter bit          REL_TS        = 1'b0
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  output logic                ap_ready,
  input  logic [TQ_WIDTH-1:0] task_in,
  input  logic                cache_inval,
  output logic                err,
  output logic                undo_log_entry_ap_vld,
  graph_fanout_enqueuer_if.master bus
);
  fanout_state_t state_q;
  logic          cache_vld_q, err_q, errb_q, arvalid_q;
  logic [31:0]   base_ofs_q, base_nbr_q, vid_q, s_q, e_q, araddr_q;
  logic [15:0]   start_q;
  logic [7:0]    arlen_q;
  ts_t           pts_q, last_ts_q;

  task_t       tin, child, split_task;
  logic        beat_bad, wt_state, rready, r_fire, child_ok, need_split, unused_ok;
  logic [32:0] span;

  assign tin        = task_t'(task_in);
  assign beat_bad   = bus.m_axi_l1_V_RRESP != 2'b00;
  assign wt_state   = state_q inside {ST_WT_BOFS, ST_WT_BNBR, ST_WT_EDGE, ST_WT_NBR};
  assign child_ok   = (state_q == ST_WT_NBR) && bus.m_axi_l1_V_RVALID && !errb_q && !beat_bad;
  // Neighbour beats are paced by the task stream unless the burst is being drained.
  assign rready     = (state_q == ST_WT_NBR) ? (errb_q || beat_bad || bus.task_out_V_TREADY)
                                             : wt_state;
  assign r_fire     = bus.m_axi_l1_V_RVALID && rready;
  assign span       = {1'b0, e_q} - {1'b0, s_q};
  assign need_split = span > 33'(CHUNK);
  assign unused_ok  = ^{tin.ttype, tin.args[63:16], 32'(CORE_ID), 32'(TILE_ID)};

  fanout_child_fmt #(
    .TS_BITS(TS_BITS), .PORT_BITS(PORT_BITS), .CHILD_TTYPE(CHILD_TTYPE), .REL_TS(REL_TS)
  ) u_fmt (
    .nbr_i(bus.m_axi_l1_V_RDATA), .pts_i(pts_q), .vid_i(vid_q), .child_o(child)
  );

  always_comb begin
    split_task           = '0;
    split_task.ttype     = 4'(SPLIT_TTYPE);
    split_task.ts        = last_ts_q;
    split_task.hint      = vid_q;
    split_task.args[15:0] = start_q + 16'(CHUNK);
  end

  assign bus.m_axi_l1_V_ARVALID = arvalid_q;
  assign bus.m_axi_l1_V_ARADDR  = araddr_q;
  assign bus.m_axi_l1_V_ARLEN   = arlen_q;
  assign bus.m_axi_l1_V_ARSIZE  = AXI_SIZE_4B;
  assign bus.m_axi_l1_V_RREADY  = rready;
  assign bus.m_axi_l1_V_AWVALID = 1'b0;
  assign bus.m_axi_l1_V_WVALID  = 1'b0;
  assign bus.m_axi_l1_V_BREADY  = 1'b1;
  assign bus.task_out_V_TVALID  = child_ok || (state_q == ST_SPLIT && need_split);
  assign bus.task_out_V_TDATA   = (state_q == ST_SPLIT) ? split_task : child;
  assign undo_log_entry_ap_vld  = 1'b0;
  assign ap_done  = state_q == ST_DONE;
  assign ap_idle  = state_q == ST_IDLE;
  assign ap_ready = state_q == ST_IDLE;
  assign err      = err_q;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= ST_IDLE;
      cache_vld_q <= 1'b0;
      err_q       <= 1'b0;
      errb_q      <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      base_ofs_q  <= '0;
      base_nbr_q  <= '0;
      vid_q       <= '0;
      start_q     <= '0;
      pts_q       <= '0;
      s_q         <= '0;
      e_q         <= '0;
      last_ts_q   <= '0;
    end else begin
      if (wt_state && r_fire && beat_bad) begin
        err_q  <= 1'b1;
        errb_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: if (ap_start) begin
          vid_q     <= tin.hint;
          start_q   <= tin.args[15:0];
          pts_q     <= tin.ts;
          err_q     <= 1'b0;
          errb_q    <= 1'b0;
          arvalid_q <= 1'b1;
          if (cache_vld_q) begin
            state_q  <= ST_RD_EDGE;
            araddr_q <= base_ofs_q + {tin.hint[29:0], 2'b00};
            arlen_q  <= 8'd1;
          end else begin
            state_q  <= ST_RD_BOFS;
            araddr_q <= BASE_OFS_ADDR;
            arlen_q  <= 8'd0;
          end
        end
        ST_RD_BOFS: if (bus.m_axi_l1_V_ARREADY) begin arvalid_q <= 1'b0; state_q <= ST_WT_BOFS; end
        ST_RD_BNBR: if (bus.m_axi_l1_V_ARREADY) begin arvalid_q <= 1'b0; state_q <= ST_WT_BNBR; end
        ST_RD_EDGE: if (bus.m_axi_l1_V_ARREADY) begin arvalid_q <= 1'b0; state_q <= ST_WT_EDGE; end
        ST_WT_BOFS: if (r_fire) begin
          base_ofs_q <= {bus.m_axi_l1_V_RDATA[29:0], 2'b00};
          if (beat_bad) state_q <= ST_DONE;
          else begin
            state_q   <= ST_RD_BNBR;
            arvalid_q <= 1'b1;
            araddr_q  <= BASE_NBR_ADDR;
            arlen_q   <= 8'd0;
          end
        end
        ST_WT_BNBR: if (r_fire) begin
          base_nbr_q <= {bus.m_axi_l1_V_RDATA[29:0], 2'b00};
          if (beat_bad) state_q <= ST_DONE;
          else begin
            cache_vld_q <= 1'b1;
            state_q     <= ST_RD_EDGE;
            arvalid_q   <= 1'b1;
            araddr_q    <= base_ofs_q + {vid_q[29:0], 2'b00};
            arlen_q     <= 8'd1;
          end
        end
        ST_WT_EDGE: if (r_fire) begin
          if (!bus.m_axi_l1_V_RLAST) s_q <= bus.m_axi_l1_V_RDATA + 32'(start_q);
          else begin
            e_q     <= bus.m_axi_l1_V_RDATA;
            state_q <= (errb_q || beat_bad) ? ST_DONE : ST_RD_NBR;
          end
        end
        // First cycle decides on the read; ARVALID is then held until accepted.
        ST_RD_NBR: if (!arvalid_q) begin
          if (s_q >= e_q) state_q <= ST_DONE;
          else begin
            arvalid_q <= 1'b1;
            araddr_q  <= base_nbr_q + {s_q[29:0], 2'b00};
            arlen_q   <= nbr_burst_len(s_q, e_q, CHUNK);
          end
        end else if (bus.m_axi_l1_V_ARREADY) begin
          arvalid_q <= 1'b0;
          state_q   <= ST_WT_NBR;
        end
        ST_WT_NBR: if (r_fire && bus.m_axi_l1_V_RLAST) begin
          last_ts_q <= child.ts;
          state_q   <= (errb_q || beat_bad) ? ST_DONE : ST_SPLIT;
        end
        ST_SPLIT: if (!need_split || bus.task_out_V_TREADY) state_q <= ST_DONE;
        default: state_q <= ST_IDLE;
      endcase
      if (cache_inval) cache_vld_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_graph_fanout_enqueuer.sv
// Directed bench: zero-wait L1 model, task-stream monitor, hand-computed expectations.
module tb_graph_fanout_enqueuer;
  import graph_fanout_enqueuer_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst, ap_start, ap_done, ap_idle, ap_ready, cache_inval, err, undo_vld;
  logic [TQ_WIDTH-1:0] task_in;
  graph_fanout_enqueuer_if bus();

  always #5 ap_clk = ~ap_clk;

  graph_fanout_enqueuer #(.CHUNK(7)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .task_in(task_in), .cache_inval(cache_inval),
    .err(err), .undo_log_entry_ap_vld(undo_vld), .bus(bus)
  );

  logic [31:0] rel_nbr, rel_vid;
  ts_t         rel_pts;
  task_t       rel_child;
  fanout_child_fmt #(.TS_BITS(24), .PORT_BITS(2), .CHILD_TTYPE(0), .REL_TS(1'b1)) u_rel (
    .nbr_i(rel_nbr), .pts_i(rel_pts), .vid_i(rel_vid), .child_o(rel_child)
  );

  int n_tests = 0, n_fail = 0, stall_checks = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; logic last; } beat_t;
  logic [31:0] mem [1024];
  beat_t       beats[$];
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  task_t       kids[$];
  logic [31:0] inj_err_addr = '1;

  function automatic task_t exp_child(input logic [31:0] w, input logic [31:0] vid);
    task_t t;
    t = '0; t.hint = vid; t.ts = {8'h00, w[23:0]}; t.args = {62'd0, w[25:24]};
    return t;
  endfunction

  // Zero-wait L1: decisions at negedge, drives at posedge+1.
  initial begin : l1_model
    logic  r_fire;
    beat_t b;
    bus.m_axi_l1_V_ARREADY = 1'b1;
    bus.m_axi_l1_V_RVALID = 1'b0; bus.m_axi_l1_V_RDATA = '0;
    bus.m_axi_l1_V_RLAST = 1'b0;  bus.m_axi_l1_V_RRESP = 2'b00;
    forever begin
      @(negedge ap_clk);
      if (ap_rst) begin
        beats.delete();
        bus.m_axi_l1_V_RVALID = 1'b0; bus.m_axi_l1_V_RLAST = 1'b0;
      end else begin
        r_fire = bus.m_axi_l1_V_RVALID && bus.m_axi_l1_V_RREADY;
        if (bus.m_axi_l1_V_ARVALID && bus.m_axi_l1_V_ARREADY) begin
          ar_addr_q.push_back(bus.m_axi_l1_V_ARADDR);
          ar_len_q.push_back(bus.m_axi_l1_V_ARLEN);
          for (int i = 0; i <= int'(bus.m_axi_l1_V_ARLEN); i++) begin
            b.addr = bus.m_axi_l1_V_ARADDR + 32'(i * 4);
            b.last = (i == int'(bus.m_axi_l1_V_ARLEN));
            beats.push_back(b);
          end
        end
        @(posedge ap_clk); #1;
        if (r_fire) void'(beats.pop_front());
        if (beats.size() > 0) begin
          bus.m_axi_l1_V_RVALID = 1'b1;
          bus.m_axi_l1_V_RDATA  = mem[beats[0].addr[11:2]];
          bus.m_axi_l1_V_RLAST  = beats[0].last;
          bus.m_axi_l1_V_RRESP  = (beats[0].addr == inj_err_addr) ? 2'b10 : 2'b00;
        end else begin
          bus.m_axi_l1_V_RVALID = 1'b0; bus.m_axi_l1_V_RLAST = 1'b0;
          bus.m_axi_l1_V_RRESP  = 2'b00;
        end
      end
    end
  end

  initial begin : stream_mon
    logic                stall_prev = 1'b0;
    logic [TQ_WIDTH-1:0] prev_data  = '0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst) stall_prev = 1'b0;
      else begin
        if (stall_prev && bus.task_out_V_TVALID) begin
          chk("stall_hold", bus.task_out_V_TDATA, prev_data);
          stall_checks++;
        end
        stall_prev = bus.task_out_V_TVALID && !bus.task_out_V_TREADY;
        prev_data  = bus.task_out_V_TDATA;
        if (bus.task_out_V_TVALID && bus.task_out_V_TREADY) kids.push_back(task_t'(bus.task_out_V_TDATA));
      end
    end
  end

  task automatic start_walk(input logic [31:0] vid, input logic [15:0] start, input ts_t pts);
    task_t t;
    t = '0; t.ttype = 4'd3; t.hint = vid; t.ts = pts; t.args[15:0] = start;
    @(posedge ap_clk); #1;
    kids.delete(); ar_addr_q.delete(); ar_len_q.delete();
    task_in = t; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge ap_clk);
      if (ap_done) seen = 1'b1;
    end
    chk({tag, "_done"}, seen, 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    task_t t;
    ap_rst = 1'b1; ap_start = 1'b0; task_in = '0; cache_inval = 1'b0;
    bus.task_out_V_TREADY = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[8] = 32'd64; mem[9] = 32'd128;
    for (int i = 0; i < 64; i++) mem[128 + i] = {6'd0, 2'(i % 4), 24'h001000 + 24'(i)};
    mem[67] = 32'd10; mem[68] = 32'd13;
    mem[69] = 32'd0;  mem[70] = 32'd20; mem[71] = 32'd20;
    mem[72] = 32'd30; mem[73] = 32'd40;

    // Reset state and tie-offs
    repeat (2) @(negedge ap_clk);
    chk("rst_handshake", {ap_idle, ap_ready, ap_done}, 3'b110);
    chk("rst_outputs", {bus.m_axi_l1_V_ARVALID, bus.m_axi_l1_V_RREADY, bus.task_out_V_TVALID, err}, 4'b0000);
    chk("write_tieoff", {bus.m_axi_l1_V_AWVALID, bus.m_axi_l1_V_WVALID, bus.m_axi_l1_V_BREADY, undo_vld}, 4'b0010);
    @(posedge ap_clk); #1; ap_rst = 1'b0;

    // Relative timestamp formatting wraps modulo 2^24
    rel_nbr = 32'h0200_0020; rel_pts = 32'h00FF_FFF0; rel_vid = 32'd9; #1;
    t = '0; t.hint = 32'd9; t.ts = 32'h0000_0010; t.args = 64'd2;
    chk("rel_ts_wrap", rel_child, t);
    rel_nbr = 32'h0100_0005; rel_pts = 32'h0000_0100; #1;
    t.ts = 32'h0000_0105; t.args = 64'd1;
    chk("rel_ts_add", rel_child, t);

    // Cold start: vid 3, offsets [10,13]
    start_walk(32'd3, 16'd0, 32'h0);
    wait_done("cold");
    chk("cold_ar_count", ar_addr_q.size(), 4);
    chk("cold_ar_bofs", {ar_addr_q[0], ar_len_q[0]}, {32'h20, 8'd0});
    chk("cold_ar_bnbr", {ar_addr_q[1], ar_len_q[1]}, {32'h24, 8'd0});
    chk("cold_ar_edge", {ar_addr_q[2], ar_len_q[2]}, {32'd268, 8'd1});
    chk("cold_ar_nbr", {ar_addr_q[3], ar_len_q[3]}, {32'd552, 8'd2});
    chk("cold_kids", kids.size(), 3);
    for (int i = 0; i < kids.size(); i++) chk("cold_child", kids[i], exp_child(mem[138 + i], 32'd3));
    chk("cold_err", err, 0);
    @(negedge ap_clk);
    chk("done_pulse", {ap_done, ap_idle}, 2'b01);

    // Warm start: offsets [0,20], start 7 -> 7 children plus continuation
    start_walk(32'd5, 16'd7, 32'h123);
    @(negedge ap_clk);
    chk("warm_ar_latency", {bus.m_axi_l1_V_ARVALID, bus.m_axi_l1_V_ARADDR, bus.m_axi_l1_V_ARLEN}, {1'b1, 32'd276, 8'd1});
    chk("arsize", bus.m_axi_l1_V_ARSIZE, 3'd2);
    wait_done("warm");
    chk("warm_ar_count", ar_addr_q.size(), 2);
    chk("warm_ar_nbr", {ar_addr_q[1], ar_len_q[1]}, {32'd540, 8'd6});
    chk("warm_kids", kids.size(), 8);
    for (int i = 0; i < 7 && i < kids.size(); i++) chk("warm_child", kids[i], exp_child(mem[135 + i], 32'd5));
    t = '0; t.ttype = 4'd1; t.hint = 32'd5; t.ts = 32'h0000_100D; t.args = 64'd14;
    chk("warm_split", kids[7], t);

    // Empty range and inverted range
    start_walk(32'd6, 16'd0, 32'h0);
    wait_done("empty");
    chk("empty_ar_count", ar_addr_q.size(), 1);
    chk("empty_kids", kids.size(), 0);
    start_walk(32'd6, 16'd3, 32'h0);
    wait_done("inverted");
    chk("inverted_ar_count", ar_addr_q.size(), 1);
    chk("inverted_kids", kids.size(), 0);

    // Read error on beat 1 of a 7-beat burst
    inj_err_addr = 32'd636;
    start_walk(32'd8, 16'd0, 32'h0);
    wait_done("rderr");
    chk("rderr_err", err, 1);
    chk("rderr_burst", {ar_addr_q[1], ar_len_q[1]}, {32'd632, 8'd6});
    chk("rderr_kids", kids.size(), 1);
    chk("rderr_child0", kids[0], exp_child(mem[158], 32'd8));
    chk("rderr_drained", beats.size(), 0);
    inj_err_addr = '1;
    @(negedge ap_clk);
    chk("err_sticky", {err, ap_idle}, 2'b11);

    // Invalidate cache; next start clears err and re-reads the bases
    @(posedge ap_clk); #1; cache_inval = 1'b1;
    @(posedge ap_clk); #1; cache_inval = 1'b0;
    start_walk(32'd6, 16'd0, 32'h0);
    @(negedge ap_clk);
    chk("err_cleared", err, 0);
    wait_done("inval");
    chk("inval_ar_count", ar_addr_q.size(), 3);
    chk("inval_ar_bofs", ar_addr_q[0], 32'h20);

    // Stall with TREADY toggling, then reset mid-burst
    start_walk(32'd5, 16'd7, 32'h0);
    for (int c = 0; c < 200 && kids.size() < 3; c++) begin
      @(posedge ap_clk); #1;
      bus.task_out_V_TREADY = ~bus.task_out_V_TREADY;
      @(negedge ap_clk);
    end
    chk("stall_kids_seen", kids.size() >= 3, 1);
    for (int i = 0; i < 3 && i < kids.size(); i++) chk("stall_child", kids[i], exp_child(mem[135 + i], 32'd5));
    chk("stall_checked", stall_checks > 0, 1);
    @(posedge ap_clk); #1;
    ap_rst = 1'b1; bus.task_out_V_TREADY = 1'b1;
    @(negedge ap_clk);
    chk("midrst_state", {ap_idle, bus.m_axi_l1_V_ARVALID, bus.task_out_V_TVALID, bus.m_axi_l1_V_RREADY}, 4'b1000);
    @(posedge ap_clk); #1; ap_rst = 1'b0;
    start_walk(32'd3, 16'd0, 32'h0);
    wait_done("post_rst");
    chk("post_rst_ar_count", ar_addr_q.size(), 4);
    chk("post_rst_ar_bofs", ar_addr_q[0], 32'h20);
    chk("post_rst_kids", kids.size(), 3);
    chk("post_rst_child0", kids[0], exp_child(mem[138], 32'd3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
